// File: rtl/p_arith_pkg.sv
// Shared definitions for the packed-arithmetic unit: arbiter state
// encoding, one-hot pack-width bit positions and default widths.
package p_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } arb_state_e;

  // Bit positions inside the one-hot pack-width field.
  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  // Default width of the ALU stall counter.
  localparam int SCW_DEF = 8;

endpackage

// File: rtl/p_addsub_arb.sv
// Arbiter sharing one packed add/sub adder between the multi-cycle
// multiplier core and the single-cycle ALU path. A multiply owns the
// adder until it completes or is aborted; the ALU is owed the first
// slot after every multiply.
module p_addsub_arb
  import p_arith_pkg::*;
#(
  parameter int SCW = SCW_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           alu_req,
  output logic           alu_gnt,
  input  logic [31:0]    alu_lhs,
  input  logic [31:0]    alu_rhs,
  input  logic [4:0]     alu_pw,
  input  logic           alu_sub,
  output logic [31:0]    alu_result,
  output logic [31:0]    alu_carry,
  input  logic           mul_req,
  output logic           mul_gnt,
  output logic           core_valid,
  input  logic           core_ready,
  output logic           mul_ready,
  input  logic [31:0]    mul_lhs,
  input  logic [31:0]    mul_rhs,
  input  logic [4:0]     mul_pw,
  input  logic           mul_sub,
  output logic [31:0]    mul_result,
  output logic [31:0]    mul_carry,
  output logic [31:0]    padd_lhs,
  output logic [31:0]    padd_rhs,
  output logic [4:0]     padd_pw,
  output logic           padd_sub,
  input  logic [31:0]    padd_result,
  input  logic [31:0]    padd_carry,
  output logic [SCW-1:0] alu_stall
);

  arb_state_e     state_q, state_d;
  logic           prefer_q, prefer_d;
  logic [SCW-1:0] stall_q, stall_d;
  logic           alu_g, mul_g;

  // Saturating increment for the stall counter.
  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next-state, grant and prefer-flag decisions.
  always_comb begin
    state_d  = state_q;
    prefer_d = prefer_q;
    alu_g    = 1'b0;
    mul_g    = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu_req && (!mul_req || prefer_q)) begin
          alu_g    = 1'b1;
          prefer_d = 1'b0;
        end else if (mul_req) begin
          // Core step 0 is taken in the grant cycle itself.
          mul_g   = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_g = mul_req;
        if (!mul_req) begin
          // Abort: core_valid drops now so the core clears itself.
          state_d  = IDLE;
          prefer_d = alu_req;
        end else if (core_ready) begin
          state_d  = IDLE;
          prefer_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // No grant at all in a reset cycle.
    if (reset) begin
      alu_g = 1'b0;
      mul_g = 1'b0;
    end
  end

  // Consecutive ungranted ALU request cycles.
  always_comb begin
    stall_d = '0;
    if (alu_req && !alu_g) stall_d = sat_inc(stall_q);
  end

  // Arbiter state, prefer flag and stall counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      prefer_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      prefer_q <= prefer_d;
      stall_q  <= stall_d;
    end
  end

  // Grant outputs and shared-adder steering.
  always_comb begin
    alu_gnt    = alu_g;
    mul_gnt    = mul_g;
    core_valid = mul_g;
    mul_ready  = core_ready & mul_g;
    alu_stall  = reset ? '0 : stall_q;
    padd_lhs   = '0;
    padd_rhs   = '0;
    padd_pw    = '0;
    padd_sub   = 1'b0;
    if (alu_g) begin
      padd_lhs = alu_lhs;
      padd_rhs = alu_rhs;
      padd_pw  = alu_pw;
      padd_sub = alu_sub;
    end else if (mul_g) begin
      padd_lhs = mul_lhs;
      padd_rhs = mul_rhs;
      padd_pw  = mul_pw;
      padd_sub = mul_sub;
    end
    alu_result = alu_g ? padd_result : '0;
    alu_carry  = alu_g ? padd_carry  : '0;
    mul_result = mul_g ? padd_result : '0;
    mul_carry  = mul_g ? padd_carry  : '0;
  end

endmodule

// File: tb/tb_p_addsub_arb.sv
// Bench for p_addsub_arb: behavioural packed adder, shift-add
// multiplier core, and a cycle reference built from the arbitration
// rules; directed scenarios followed by randomized traffic.
module tb_p_addsub_arb;
  import p_arith_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, alu_req, alu_sub, mul_req, mul_sub, core_ready;
  logic [31:0] alu_lhs, alu_rhs, mul_lhs, mul_rhs, padd_result, padd_carry;
  logic [4:0]  alu_pw, mul_pw;
  logic        alu_gnt, mul_gnt, core_valid, mul_ready, padd_sub;
  logic [31:0] alu_result, alu_carry, mul_result, mul_carry, padd_lhs, padd_rhs;
  logic [4:0]  padd_pw;
  logic [7:0]  alu_stall;
  // Second instance with a 2-bit stall counter.
  logic        alu_gnt2, mul_gnt2, core_valid2, mul_ready2, padd_sub2;
  logic [31:0] alu_result2, alu_carry2, mul_result2, mul_carry2, padd_lhs2, padd_rhs2;
  logic [4:0]  padd_pw2;
  logic [1:0]  alu_stall2;

  p_addsub_arb #(.SCW(8)) u_dut (
    .clock(clock), .reset(reset), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_pw(alu_pw), .alu_sub(alu_sub),
    .alu_result(alu_result), .alu_carry(alu_carry), .mul_req(mul_req),
    .mul_gnt(mul_gnt), .core_valid(core_valid), .core_ready(core_ready),
    .mul_ready(mul_ready), .mul_lhs(mul_lhs), .mul_rhs(mul_rhs), .mul_pw(mul_pw),
    .mul_sub(mul_sub), .mul_result(mul_result), .mul_carry(mul_carry),
    .padd_lhs(padd_lhs), .padd_rhs(padd_rhs), .padd_pw(padd_pw),
    .padd_sub(padd_sub), .padd_result(padd_result), .padd_carry(padd_carry),
    .alu_stall(alu_stall)
  );

  p_addsub_arb #(.SCW(2)) u_dut2 (
    .clock(clock), .reset(reset), .alu_req(alu_req), .alu_gnt(alu_gnt2),
    .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_pw(alu_pw), .alu_sub(alu_sub),
    .alu_result(alu_result2), .alu_carry(alu_carry2), .mul_req(mul_req),
    .mul_gnt(mul_gnt2), .core_valid(core_valid2), .core_ready(core_ready),
    .mul_ready(mul_ready2), .mul_lhs(mul_lhs), .mul_rhs(mul_rhs), .mul_pw(mul_pw),
    .mul_sub(mul_sub), .mul_result(mul_result2), .mul_carry(mul_carry2),
    .padd_lhs(padd_lhs2), .padd_rhs(padd_rhs2), .padd_pw(padd_pw2),
    .padd_sub(padd_sub2), .padd_result(padd_result), .padd_carry(padd_carry),
    .alu_stall(alu_stall2)
  );

  function automatic int lane_w(input logic [4:0] pw);
    case (pw)
      5'b00001: return 32;
      5'b00010: return 16;
      5'b00100: return 8;
      5'b01000: return 4;
      5'b10000: return 2;
      default:  return 0;
    endcase
  endfunction

  // Packed add/sub: {carry, result}; carry-out of each lane at its LSB.
  function automatic logic [63:0] addsub(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] pw, input logic sub);
    int w;
    longint mask, la, lb, s;
    logic [31:0] r, c;
    w = lane_w(pw);
    r = 32'h0;
    c = 32'h0;
    if (w != 0) begin
      mask = (longint'(1) << w) - 1;
      for (int l = 0; l < 32 / w; l++) begin
        la = longint'(a >> (l * w)) & mask;
        lb = longint'(b >> (l * w)) & mask;
        s  = sub ? la + ((~lb) & mask) + 1 : la + lb;
        r  = r | (32'(s & mask) << (l * w));
        c  = c | (32'((s >> w) & 1) << (l * w));
      end
    end
    return {c, r};
  endfunction

  always_comb {padd_carry, padd_result} = addsub(padd_lhs, padd_rhs, padd_pw, padd_sub);

  // Shift-add multiplier core: one adder step per valid cycle, ready
  // after lane-width + 1 steps, self-clearing when valid drops.
  logic [5:0]  cnt = 6'd0;
  logic [31:0] psum = 32'h0, crs1, crs2;
  always_comb core_ready = core_valid && (lane_w(mul_pw) != 0) && (cnt == 6'(lane_w(mul_pw)));
  always_comb begin
    mul_lhs = psum;
    mul_rhs = (cnt < 6'd32 && crs2[cnt[4:0]]) ? (crs1 << cnt) : 32'h0;
  end
  always @(posedge clock) begin
    if (core_valid && !core_ready) begin
      cnt  <= cnt + 6'd1;
      psum <= mul_result;
    end else begin
      cnt  <= 6'd0;
      psum <= 32'h0;
    end
  end

  int nchk = 0, nbad = 0;
  bit m_busy = 0, m_owed = 0;
  int m_wait = 0;
  logic r_alu, r_mul, r_cv, r_rdy;
  logic [31:0] r_alures, r_mulres;
  logic [7:0] r_stall;
  logic [1:0] r_stall2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: settle, compare everything against the reference, advance it.
  task automatic step();
    logic ea, em;
    logic [63:0] ar, mr;
    logic [31:0] el, er;
    logic [4:0]  ep;
    logic        es;
    int s1, s2;
    #4;
    ea = 1'b0;
    em = 1'b0;
    if (!reset) begin
      if (m_busy) em = mul_req;
      else if (alu_req && (!mul_req || m_owed)) ea = 1'b1;
      else if (mul_req) em = 1'b1;
    end
    ar = ea ? addsub(alu_lhs, alu_rhs, alu_pw, alu_sub) : 64'h0;
    mr = em ? addsub(mul_lhs, mul_rhs, mul_pw, mul_sub) : 64'h0;
    el = ea ? alu_lhs : (em ? mul_lhs : 32'h0);
    er = ea ? alu_rhs : (em ? mul_rhs : 32'h0);
    ep = ea ? alu_pw  : (em ? mul_pw  : 5'h0);
    es = ea ? alu_sub : (em ? mul_sub : 1'b0);
    s1 = reset ? 0 : (m_wait > 255 ? 255 : m_wait);
    s2 = reset ? 0 : (m_wait > 3 ? 3 : m_wait);
    chk("alu_gnt", 32'(alu_gnt), 32'(ea));
    chk("mul_gnt", 32'(mul_gnt), 32'(em));
    chk("core_valid", 32'(core_valid), 32'(em));
    chk("mul_ready", 32'(mul_ready), 32'(em & core_ready));
    chk("alu_result", alu_result, ar[31:0]);
    chk("alu_carry", alu_carry, ar[63:32]);
    chk("mul_result", mul_result, mr[31:0]);
    chk("mul_carry", mul_carry, mr[63:32]);
    chk("padd_lhs", padd_lhs, el);
    chk("padd_rhs", padd_rhs, er);
    chk("padd_pw", 32'(padd_pw), 32'(ep));
    chk("padd_sub", 32'(padd_sub), 32'(es));
    chk("alu_stall", 32'(alu_stall), 32'(s1));
    chk("alu_stall_scw2", 32'(alu_stall2), 32'(s2));
    chk("alu_gnt_scw2", 32'(alu_gnt2), 32'(ea));
    chk("mul_gnt_scw2", 32'(mul_gnt2), 32'(em));
    r_alu = alu_gnt; r_mul = mul_gnt; r_cv = core_valid; r_rdy = mul_ready;
    r_alures = alu_result; r_mulres = mul_result;
    r_stall = alu_stall; r_stall2 = alu_stall2;
    if (reset) begin
      m_busy = 0; m_owed = 0; m_wait = 0;
    end else begin
      if (m_busy) begin
        if (!mul_req) begin m_busy = 0; m_owed = alu_req; end
        else if (core_ready) begin m_busy = 0; m_owed = 1; end
      end else if (ea) m_owed = 0;
      else if (em) m_busy = 1;
      m_wait = (alu_req && !ea) ? m_wait + 1 : 0;
    end
    @(posedge clock);
    #1;
  endtask

  // Run a started multiply to its ready cycle; returns valid-cycle count.
  task automatic run_mul(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (r_cv) n++;
      if (r_rdy) break;
    end
  endtask

  initial begin
    int n;
    logic prev_rdy;
    logic [31:0] exp_prod;
    reset = 1; alu_req = 0; alu_lhs = 0; alu_rhs = 0; alu_pw = 0; alu_sub = 0;
    mul_req = 0; mul_pw = 5'b00001; mul_sub = 0; crs1 = 0; crs2 = 0;
    @(posedge clock); #1;

    // Reset cycle with both requests high: everything stays quiet.
    alu_req = 1; mul_req = 1;
    step();
    chk("rst_grants", {29'h0, r_alu, r_mul, r_cv}, 32'h0);
    chk("rst_stall", 32'(r_stall), 32'h0);
    alu_req = 0; mul_req = 0;
    step();
    reset = 0;

    // ALU only, pw8.
    alu_req = 1; alu_lhs = 32'h01020304; alu_rhs = 32'h01010101; alu_pw = 5'b00100;
    step();
    chk("alu_only_gnt", 32'(r_alu), 32'h1);
    chk("alu_only_res", r_alures, 32'h02030405);
    chk("alu_only_stall", 32'(r_stall), 32'h0);
    // pw = 0 yields a zero sum.
    alu_pw = 5'b00000;
    step();
    chk("pw0_res", r_alures, 32'h0);
    alu_req = 0;

    // Multiply only, pw32, 3 * 5.
    crs1 = 3; crs2 = 5; mul_pw = 5'b00001; mul_req = 1;
    run_mul(n);
    chk("mul_only_len", n, 33);
    chk("mul_only_prod", r_mulres, 32'd15);
    mul_req = 0;
    step();
    chk("mul_only_idle", 32'(r_mul), 32'h0);

    // Simultaneous requests after reset: multiply first, ALU right after.
    reset = 1; step(); reset = 0;
    crs1 = 32'd1234; crs2 = 32'd4321; alu_req = 1; alu_pw = 5'b00001;
    alu_lhs = $urandom; alu_rhs = $urandom; mul_req = 1;
    step();
    chk("both_mul_first", 32'(r_mul), 32'h1);
    prev_rdy = r_rdy;
    for (int i = 0; i < 60; i++) begin
      prev_rdy = r_rdy;
      step();
      if (r_alu) break;
    end
    chk("both_alu_gnt", 32'(r_alu), 32'h1);
    chk("both_after_rdy", 32'(prev_rdy), 32'h1);
    chk("both_stall33", 32'(r_stall), 32'd33);
    chk("scw2_saturate", 32'(r_stall2), 32'd3);
    step();
    chk("both_restart", 32'(r_mul), 32'h1);
    chk("stall_cleared", 32'(r_stall), 32'h0);
    chk("scw2_cleared", 32'(r_stall2), 32'h0);
    run_mul(n);
    chk("both_second_len", n, 32);
    mul_req = 0;
    step();
    chk("both_owed_alu", 32'(r_alu), 32'h1);
    alu_req = 0;
    step();

    // Abort after 10 multiply cycles with an ALU request waiting.
    crs1 = $urandom; crs2 = $urandom; mul_req = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) alu_req = 1;
      step();
    end
    mul_req = 0;
    step();
    chk("abort_cv", 32'(r_cv), 32'h0);
    chk("abort_alu_blocked", 32'(r_alu), 32'h0);
    step();
    chk("abort_alu_gnt", 32'(r_alu), 32'h1);
    alu_req = 0;

    // Reset during multiply cycle 5, then a fresh full multiply.
    crs1 = $urandom_range(65535); crs2 = $urandom_range(65535); mul_req = 1;
    for (int i = 0; i < 4; i++) step();
    reset = 1;
    step();
    chk("midrst_quiet", {29'h0, r_alu, r_mul, r_cv}, 32'h0);
    reset = 0;
    exp_prod = crs1 * crs2;
    run_mul(n);
    chk("midrst_len", n, 33);
    chk("midrst_prod", r_mulres, exp_prod);
    mul_req = 0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      step();
      if (reset) reset = 0;
      else if ($urandom_range(199) == 0) reset = 1;
      if (r_rdy && mul_pw == 5'b00001) chk("rnd_prod", r_mulres, crs1 * crs2);
      if (r_alu || reset) alu_req = 0;
      if (!alu_req && $urandom_range(2) == 0) begin
        alu_req = 1; alu_lhs = $urandom; alu_rhs = $urandom; alu_sub = 1'($urandom);
        case ($urandom_range(5))
          0: alu_pw = 5'b00000;
          default: alu_pw = 5'b00001 << $urandom_range(4);
        endcase
      end
      if (r_rdy || reset) mul_req = 0;
      else if (r_mul && $urandom_range(63) == 0) mul_req = 0;
      else if (!mul_req && $urandom_range(7) == 0) begin
        mul_req = 1; crs1 = $urandom; crs2 = $urandom;
        mul_pw = 5'b00001 << $urandom_range(4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule
